// File: rtl/clk_gen_pkg.sv
// Shared types and default widths for the
// clk_gen ring-oscillator frequency meter.
package clk_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_POST
  } meter_state_e;

endpackage

// File: rtl/clk_gen_edge_sync.sv
// Multi-flop synchronizer plus delay flop;
// flags a rising edge of an async input.
module clk_gen_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/clk_gen_freq_meter.sv
// Gated edge counter: counts osc_in rising edges
// over a programmable window of clk cycles.
module clk_gen_freq_meter
  import clk_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             osc_in,
  input  logic             start_i,
  input  logic [WIN_W-1:0] window_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  meter_state_e     state_q, state_d;
  logic [ARM_W-1:0] arm_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_d;
  logic             ovf_q, ovf_d;
  logic             rise, cnt_sat;

  clk_gen_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_in(osc_in),
    .rise_o  (rise)
  );

  assign cnt_sat = (edge_cnt == CNT_MAX);
  assign edge_d  = (rise && !cnt_sat) ? edge_cnt + 1'b1 : edge_cnt;
  assign ovf_d   = ovf_q | (rise & cnt_sat);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start_i) state_d = ST_ARM;
      ST_ARM:
        if (arm_cnt == ARM_LAST)
          state_d = (win_cnt == '0) ? ST_POST : ST_MEASURE;
      ST_MEASURE:
        if (win_cnt == WIN_ONE) state_d = ST_POST;
      ST_POST:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt  <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (start_i) begin
            arm_cnt  <= '0;
            win_cnt  <= window_i;
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
          end
        ST_ARM:
          arm_cnt <= arm_cnt + 1'b1;
        ST_MEASURE: begin
          win_cnt  <= win_cnt - 1'b1;
          edge_cnt <= edge_d;
          ovf_q    <= ovf_d;
        end
        default: ;
      endcase
    end
  end

  // result lands on entry to POST so it is valid alongside done_o
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else if (state_d == ST_POST) begin
      if (state_q == ST_MEASURE) begin
        count_o    <= edge_d;
        overflow_o <= ovf_d;
      end else if (state_q == ST_ARM) begin
        count_o    <= '0;
        overflow_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q == ST_ARM) || (state_q == ST_MEASURE);
  assign done_o = (state_q == ST_POST);

endmodule

// File: tb/tb_clk_gen_freq_meter.sv
// Randomized bench for clk_gen_freq_meter with an
// edge-list reference model of the gated count.
module tb_clk_gen_freq_meter;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        osc_in = 1'b0;
  logic        start_a, start_b;
  logic [15:0] window_a, window_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int osc_mode  = 2;
  bit osc_hold  = 1'b0;
  int per       = 8;
  int ph        = 0;
  int run_left  = 0;
  bit rise_edge [0:65535];

  clk_gen_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .reset_n(reset_n), .osc_in(osc_in),
    .start_i(start_a), .window_i(window_a),
    .busy_o(busy_a), .done_o(done_a),
    .count_o(count_a), .overflow_o(ovf_a)
  );

  clk_gen_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .reset_n(reset_n), .osc_in(osc_in),
    .start_i(start_b), .window_i(window_b),
    .busy_o(busy_b), .done_o(done_b),
    .count_o(count_b), .overflow_o(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // osc_in changes on negedge; a rise is tagged with
  // the posedge index that first samples it high
  always @(negedge clk) begin
    bit nv;
    nv = osc_in;
    case (osc_mode)
      0: nv = osc_hold;
      1: begin
        ph = (ph + 1) % per;
        nv = (ph < per / 2);
      end
      default:
        if (run_left == 0) begin
          nv = ~osc_in;
          run_left = $urandom_range(3, 1);
        end else begin
          run_left--;
        end
    endcase
    if (nv && !osc_in) rise_edge[cyc+1] = 1'b1;
    osc_in = nv;
  end

  // edges sampled in the w-cycle gate that opens SYNC
  // posedges after the start edge e0 are counted
  function automatic void model(input int e0, input int w,
                                input int cw, output int c,
                                output bit ov);
    int n;
    int mx;
    n  = 0;
    mx = (1 << cw) - 1;
    for (int k = e0 + SYNC; k < e0 + SYNC + w; k++)
      if (rise_edge[k]) n++;
    ov = (n > mx);
    c  = ov ? mx : n;
  endfunction

  task automatic run_meas(input bit sel, input int w, input int rp,
                          output int lat, output int nbusy,
                          output int ndone, output int cnt,
                          output bit ov, output int cnt_end,
                          output int e0);
    int budget;
    bit b, d;
    budget = w + 20;
    lat = -1; nbusy = 0; ndone = 0; cnt = -1; ov = 1'b0;
    @(negedge clk);
    if (sel) begin start_b = 1'b1; window_b = 16'(w); end
    else     begin start_a = 1'b1; window_a = 16'(w); end
    e0 = cyc + 1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1 || i == rp + 1) begin
        start_a = 1'b0; start_b = 1'b0;
        window_a = 16'($urandom); window_b = 16'($urandom);
      end
      if (i == rp) begin
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
      end
      b = sel ? busy_b : busy_a;
      d = sel ? done_b : done_a;
      if (b) nbusy++;
      if (d) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          cnt = sel ? int'(count_b) : int'(count_a);
          ov  = sel ? ovf_b : ovf_a;
        end
      end
    end
    cnt_end = sel ? int'(count_b) : int'(count_a);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    window_a = '0;  window_b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_a, done_a, ovf_a, busy_b, done_b, ovf_b} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {busy_a, done_a, ovf_a, busy_b, done_b, ovf_b});
    end
    total++;
    if (count_a !== 16'd0 || count_b !== 4'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d/%0d want=0/0", count_a, count_b);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_period8;
    int lat, nb, nd, c, ce, e0, ec;
    bit ov, eov;
    osc_mode = 1; per = 8;
    run_meas(1'b0, 800, 0, lat, nb, nd, c, ov, ce, e0);
    model(e0, 800, 16, ec, eov);
    total++;
    if (lat !== 804) begin
      bad++; $display("FAIL p8_latency got=%0d want=804", lat);
    end
    total++;
    if (c !== ec || ov !== eov) begin
      bad++;
      $display("FAIL p8_count got=%0d/%0b want=%0d/%0b", c, ov, ec, eov);
    end
    total++;
    if (c < 99 || c > 101) begin
      bad++; $display("FAIL p8_range got=%0d want=100+-1", c);
    end
    total++;
    if (ce !== c) begin
      bad++; $display("FAIL p8_hold got=%0d want=%0d", ce, c);
    end
  endtask

  task automatic test_zero_window;
    int lat, nb, nd, c, ce, e0;
    bit ov;
    osc_mode = 2;
    run_meas(1'b0, 0, 0, lat, nb, nd, c, ov, ce, e0);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL w0_latency got=%0d want=4", lat);
    end
    total++;
    if (c !== 0 || ov !== 1'b0) begin
      bad++; $display("FAIL w0_count got=%0d/%0b want=0/0", c, ov);
    end
    total++;
    if (nb !== 3 || nd !== 1) begin
      bad++; $display("FAIL w0_busy got=%0d/%0d want=3/1", nb, nd);
    end
  endtask

  task automatic test_overflow;
    int lat, nb, nd, c, ce, e0, ec;
    bit ov, eov;
    osc_mode = 1; per = 4;
    run_meas(1'b1, 100, 0, lat, nb, nd, c, ov, ce, e0);
    model(e0, 100, 4, ec, eov);
    total++;
    if (c !== 15 || ov !== 1'b1) begin
      bad++; $display("FAIL ovf_count got=%0d/%0b want=15/1", c, ov);
    end
    total++;
    if (c !== ec || ov !== eov || lat !== 104) begin
      bad++;
      $display("FAIL ovf_model got=%0d/%0b lat=%0d want=%0d/%0b lat=104",
               c, ov, lat, ec, eov);
    end
  endtask

  task automatic test_random;
    int lat, nb, nd, c, ce, e0, ec, w, cw;
    bit ov, eov, sel;
    osc_mode = 2;
    for (int it = 0; it < 10; it++) begin
      w   = (it < 2) ? it + 1 : int'($urandom_range(300, 3));
      sel = it[0];
      cw  = sel ? 4 : 16;
      run_meas(sel, w, 0, lat, nb, nd, c, ov, ce, e0);
      model(e0, w, cw, ec, eov);
      total++;
      if (lat !== w + SYNC + 2 || nd !== 1 || nb !== w + SYNC + 1) begin
        bad++;
        $display("FAIL rnd%0d_timing got=lat%0d/done%0d/busy%0d w=%0d",
                 it, lat, nd, nb, w);
      end
      total++;
      if (c !== ec || ov !== eov || ce !== ec) begin
        bad++;
        $display("FAIL rnd%0d_count got=%0d/%0b/%0d want=%0d/%0b w=%0d",
                 it, c, ov, ce, ec, eov, w);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb, nd, c, ce, e0, ec;
    bit ov, eov;
    osc_mode = 2;
    run_meas(1'b0, 100, 20, lat, nb, nd, c, ov, ce, e0);
    model(e0, 100, 16, ec, eov);
    total++;
    if (nd !== 1 || lat !== 104) begin
      bad++; $display("FAIL b2b_done got=%0d/lat%0d want=1/104", nd, lat);
    end
    total++;
    if (c !== ec || ov !== eov) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", c, ec);
    end
  endtask

  task automatic test_reset_abort;
    int nd, lat, nb, c, ce, e0, ec;
    bit ov, eov;
    osc_mode = 2;
    nd = 0;
    @(negedge clk);
    start_a = 1'b1; window_a = 16'd200;
    @(negedge clk);
    start_a = 1'b0;
    repeat (49) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_a, done_a, ovf_a} !== 3'b0 || count_a !== 16'd0) begin
      bad++;
      $display("FAIL abort_outputs got=%b cnt=%0d want=000 cnt=0",
               {busy_a, done_a, ovf_a}, count_a);
    end
    reset_n = 1'b1;
    repeat (220) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    total++;
    if (nd !== 0 || count_a !== 16'd0) begin
      bad++;
      $display("FAIL abort_nodone got=%0d cnt=%0d want=0 cnt=0", nd, count_a);
    end
    run_meas(1'b0, 150, 0, lat, nb, nd, c, ov, ce, e0);
    model(e0, 150, 16, ec, eov);
    total++;
    if (c !== ec || ov !== eov || lat !== 154) begin
      bad++;
      $display("FAIL abort_next got=%0d lat=%0d want=%0d lat=154", c, lat, ec);
    end
  endtask

  task automatic test_const_high;
    int lat, nb, nd, c, ce, e0;
    bit ov;
    osc_hold = 1'b1; osc_mode = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_meas(1'b0, 40, 0, lat, nb, nd, c, ov, ce, e0);
    total++;
    if (c !== 0 || ov !== 1'b0 || nd !== 1) begin
      bad++;
      $display("FAIL const_high got=%0d/%0b/%0d want=0/0/1", c, ov, nd);
    end
  endtask

  initial begin
    test_reset();
    test_period8();
    test_zero_window();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_const_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_gen_freq_meter.md
CLK_GEN_FREQ_METER -- requirements
Module: clk_gen_freq_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the result counter width in bits.
REQ-002 The block SHALL have parameter WIN_W, default 16, giving the gate-window length width in bits.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the osc_in synchronizer depth (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single reference clock; all flops are on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port osc_in, input, 1 bit: the ring-oscillator output (pre-divided), asynchronous to clk.
REQ-007 The block SHALL have port start_i, input, 1 bit: a one-cycle request to begin a measurement.
REQ-008 The block SHALL have port window_i, input, WIN_W bits: the gate length in clk cycles, sampled at start.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while a measurement is in progress.
REQ-010 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse when a result is posted.
REQ-011 The block SHALL have port count_o, output, CNT_W bits: the osc_in rising-edge count of the last completed window.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: set when the last count saturated.

Function
REQ-013 osc_in SHALL pass through SYNC_STAGES flops, then one further delay flop; a rising edge SHALL be detected as sync_last=1 and delayed=0.
REQ-014 The FSM SHALL have states IDLE, ARM, MEASURE and POST.
REQ-015 IDLE: start_i=1 SHALL latch window_i into win_cnt, clear edge_cnt and the overflow flag, and go to ARM.
REQ-016 ARM SHALL last exactly SYNC_STAGES+1 cycles so the synchronizer is flushed, then go to MEASURE.
REQ-017 MEASURE: each cycle SHALL decrement win_cnt and increment edge_cnt on every detected edge; the transition to POST SHALL occur in the cycle win_cnt reaches 1, including that cycle's edge.
REQ-018 POST SHALL last one cycle: count_o and overflow_o load, done_o=1, then return to IDLE.
REQ-019 Latency SHALL be: start cycle + (SYNC_STAGES+1) + window_i + 1 cycles until the done_o pulse.
REQ-020 busy_o SHALL be high in ARM and MEASURE and low in IDLE and POST.
REQ-021 window_i=0 SHALL skip MEASURE (ARM goes to POST) and post count_o=0 with overflow_o=0.
REQ-022 edge_cnt SHALL saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set the overflow flag, and the counter SHALL NOT wrap.
REQ-023 start_i while busy or in POST SHALL be ignored; no queuing.
REQ-024 count_o and overflow_o SHALL hold their value between POST cycles.
REQ-025 Correct counts SHALL be guaranteed only for f(osc_in) < f(clk)/2; faster inputs give an undefined count without a hang.

Reset
REQ-026 reset_n low SHALL asynchronously force: FSM=IDLE, the synchronizer and delay flops=0, win_cnt=0, edge_cnt=0, busy_o=0, done_o=0, count_o=0, overflow_o=0.
REQ-027 Reset mid-measurement SHALL abort the measurement with no done_o pulse, and count_o SHALL read 0 afterwards.
REQ-028 Release of reset_n SHALL be followed by IDLE with no spurious edge counted in the first measurement.

Structure
REQ-029 FSM state encoding and the default CNT_W/WIN_W constants SHALL live in the shared package clk_gen_pkg.
REQ-030 The synchronizer plus edge detector SHALL be the sub-module clk_gen_edge_sync (ports clk, reset_n, async_in, rise_o).
REQ-031 There SHALL be no other hierarchy and no latches or combinational loops.

Verification
REQ-032 Scenario: osc_in period 8 clk cycles, window_i=800, start pulse -> done_o after 804 cycles, count_o=100±1, overflow_o=0.
REQ-033 Scenario: window_i=0 -> done_o 4 cycles after start, count_o=0, busy_o high for exactly 3 cycles.
REQ-034 Scenario: CNT_W=4, osc period 4, window_i=100 -> count_o=15, overflow_o=1.
REQ-035 Scenario: start_i re-pulsed during MEASURE -> exactly one done_o, and the result matches the first window.
REQ-036 Scenario: reset_n asserted at cycle 50 of a 200-cycle window -> no done_o, all outputs 0, and the next measurement is correct.
REQ-037 Scenario: osc_in held constant 1 through reset release and start -> count_o=0.
